// File: rtl/ibexc_trace_pkg.sv
// ----------------------------------------------------------------------------
// ibexc_trace_pkg
// Shared types and constants for the RVFI trace buffer:
//   - trace_rec_t : one captured retirement, stored as four 32-bit words
//                   (W0 = pc, W1 = insn, W2 = rd_wdata, W3 = meta)
//   - TRACE_WORDS : number of words per record
//   - META_*      : bit positions inside the meta word
//   - ser_state_e : serializer state encoding
//   - pack_meta() : builds the meta word from retirement fields
// ----------------------------------------------------------------------------
package ibexc_trace_pkg;

    localparam int unsigned TRACE_WORDS = 4;

    localparam int unsigned META_OVF_BIT  = 31;
    localparam int unsigned META_TRAP_BIT = 30;
    localparam int unsigned META_INTR_BIT = 29;
    localparam int unsigned META_HALT_BIT = 28;
    localparam int unsigned META_MODE_LSB = 26;
    localparam int unsigned META_RD_LSB   = 21;
    localparam int unsigned META_ORDER_W  = 16;

    // Field order puts W0 in the least significant 32 bits.
    typedef struct packed {
        logic [31:0] meta;
        logic [31:0] rd_wdata;
        logic [31:0] insn;
        logic [31:0] pc;
    } trace_rec_t;

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_W0,
        SER_W1,
        SER_W2,
        SER_W3
    } ser_state_e;

    // Bits [20:16] are left at zero.
    function automatic logic [31:0] pack_meta(
        input logic        ovf,
        input logic        trap,
        input logic        intr,
        input logic        halt,
        input logic [1:0]  mode,
        input logic [4:0]  rd_addr,
        input logic [15:0] order
    );
        logic [31:0] m;
        m                          = '0;
        m[META_OVF_BIT]            = ovf;
        m[META_TRAP_BIT]           = trap;
        m[META_INTR_BIT]           = intr;
        m[META_HALT_BIT]           = halt;
        m[META_MODE_LSB +: 2]      = mode;
        m[META_RD_LSB +: 5]        = rd_addr;
        m[META_ORDER_W-1:0]        = order;
        return m;
    endfunction

endpackage

// File: rtl/ibexc_trace_fifo.sv
// ----------------------------------------------------------------------------
// ibexc_trace_fifo
// Circular record store for the trace buffer.
//   clk_i, rst_i  : clock, asynchronous active-high reset (clears pointers)
//   push_i        : write data_i at the tail; the caller only pushes when not
//                   full, or when full while popping in the same cycle
//   data_i        : record to store
//   pop_i         : drop the head record
//   data_o        : head record (combinational read)
//   full_o        : Depth records stored
//   empty_o       : no records stored
//   one_left_o    : exactly one record stored
// Pointers carry one extra wrap bit so full and empty can be told apart.
// ----------------------------------------------------------------------------
module ibexc_trace_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 128
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             one_left_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  level;
    logic [Width-1:0] mem_q [Depth];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone decide what is valid. A push
    // while full and popping lands in the slot that is being released.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        end
    end

    assign level      = wr_ptr_q - rd_ptr_q;
    assign data_o     = mem_q[rd_ptr_q[AddrW-1:0]];
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                        (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign one_left_o = (level == PtrW'(1));

endmodule

// File: rtl/ibexc_rvfi_trace_buf.sv
// ----------------------------------------------------------------------------
// ibexc_rvfi_trace_buf
// Captures RVFI retirements into a record buffer and streams each record out
// as four 32-bit words with a valid/ready handshake.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   trace_en_i         : enables capture (draining continues when low)
//   rvfi_*             : core retirement port
//   out_valid_o/_ready_i/_data_o/_last_o : word stream, last marks W3 (meta)
//   overflow_o         : sticky, set when a record is dropped, cleared when the
//                        next record (which carries meta[31]=1) is accepted
//   ovf_cnt_o          : saturating dropped-record count
// Optional feature: define IBEXC_TRACE_OVF_CNT_EN to build the drop counter;
// otherwise ovf_cnt_o is tied to zero.
// ----------------------------------------------------------------------------
module ibexc_rvfi_trace_buf
    import ibexc_trace_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trace_en_i,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic [31:0] rvfi_insn,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [1:0]  rvfi_mode,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    output logic        overflow_o,
    output logic [15:0] ovf_cnt_o
);

    localparam int unsigned RecW = TRACE_WORDS * 32;

    ser_state_e  state_q, state_d;
    logic        overflow_q, overflow_d;
    trace_rec_t  cap_rec;
    trace_rec_t  head_rec;
    logic [RecW-1:0] head_bits;
    logic        fifo_full, fifo_empty, fifo_one_left;
    logic        cap_req, push_acc, drop, pop;
    logic        handshake;
    logic        unused_order_hi;

    // Only order[15:0] is traced.
    assign unused_order_hi = ^rvfi_order[63:16];

    // A full buffer can still take a record when the head record is leaving
    // in the same cycle.
    assign cap_req  = rvfi_valid && trace_en_i;
    assign push_acc = cap_req && (!fifo_full || pop);
    assign drop     = cap_req && fifo_full && !pop;

    always_comb begin
        cap_rec          = '0;
        cap_rec.pc       = rvfi_pc_rdata;
        cap_rec.insn     = rvfi_insn;
        cap_rec.rd_wdata = rvfi_rd_wdata;
        cap_rec.meta     = pack_meta(overflow_q, rvfi_trap, rvfi_intr, rvfi_halt,
                                     rvfi_mode, rvfi_rd_addr, rvfi_order[15:0]);
    end

    ibexc_trace_fifo #(
        .Depth (Depth),
        .Width (RecW)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push_acc),
        .data_i     (cap_rec),
        .pop_i      (pop),
        .data_o     (head_bits),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .one_left_o (fifo_one_left)
    );

    assign head_rec  = trace_rec_t'(head_bits);
    assign handshake = out_valid_o && out_ready_i;

    // Serializer: the head record is only popped after its meta word is taken.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            SER_IDLE: if (!fifo_empty) state_d = SER_W0;
            SER_W0:   if (handshake)   state_d = SER_W1;
            SER_W1:   if (handshake)   state_d = SER_W2;
            SER_W2:   if (handshake)   state_d = SER_W3;
            SER_W3: begin
                if (handshake) begin
                    pop = 1'b1;
                    // A record pushed this cycle counts as remaining.
                    state_d = (!fifo_one_left || push_acc) ? SER_W0 : SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        out_data_o = '0;
        unique case (state_q)
            SER_W0:  out_data_o = head_rec.pc;
            SER_W1:  out_data_o = head_rec.insn;
            SER_W2:  out_data_o = head_rec.rd_wdata;
            SER_W3:  out_data_o = head_rec.meta;
            default: out_data_o = '0;
        endcase
    end

    assign out_valid_o = (state_q != SER_IDLE);
    assign out_last_o  = (state_q == SER_W3);

    // Accepting a record consumes the pending overflow marker it carries.
    always_comb begin
        overflow_d = overflow_q;
        if (push_acc) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SER_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

`ifdef IBEXC_TRACE_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibexc_rvfi_trace_buf.sv
// ----------------------------------------------------------------------------
// tb_ibexc_rvfi_trace_buf
// Self-checking bench for ibexc_rvfi_trace_buf. A record-level reference model
// (a queue of four-word records plus the index of the word on offer) predicts
// every output on every cycle; directed scenarios add fixed-value checks.
// ----------------------------------------------------------------------------
module tb_ibexc_rvfi_trace_buf;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        trace_en_i = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_insn = '0;
    logic        rvfi_trap = 1'b0;
    logic        rvfi_halt = 1'b0;
    logic        rvfi_intr = 1'b0;
    logic [1:0]  rvfi_mode = '0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [31:0] rvfi_rd_wdata = '0;
    logic [31:0] rvfi_pc_rdata = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        overflow_o;
    logic [15:0] ovf_cnt_o;

    int check_count = 0;
    int error_count = 0;

    // Reference model state
    logic [127:0] m_q[$];
    int           m_idx = -1;
    bit           m_ovf = 1'b0;
    int           m_cnt = 0;

    ibexc_rvfi_trace_buf #(.Depth(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .trace_en_i    (trace_en_i),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_halt     (rvfi_halt),
        .rvfi_intr     (rvfi_intr),
        .rvfi_mode     (rvfi_mode),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_rd_wdata (rvfi_rd_wdata),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .overflow_o    (overflow_o),
        .ovf_cnt_o     (ovf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] expCnt();
`ifdef IBEXC_TRACE_OVF_CNT_EN
        return 16'(m_cnt);
`else
        return 16'h0;
`endif
    endfunction

    task automatic randPayload();
        rvfi_order    = {$urandom, $urandom};
        rvfi_insn     = $urandom;
        rvfi_trap     = 1'($urandom);
        rvfi_halt     = 1'($urandom);
        rvfi_intr     = 1'($urandom);
        rvfi_mode     = 2'($urandom);
        rvfi_rd_addr  = 5'($urandom);
        rvfi_rd_wdata = $urandom;
        rvfi_pc_rdata = $urandom;
    endtask

    task automatic compareModel();
        checkOutput("valid", out_valid_o, m_idx >= 0);
        checkOutput("last", out_last_o, m_idx == 3);
        if (m_idx >= 0) begin
            checkOutput("data", out_data_o, m_q[0][32*m_idx +: 32]);
        end
        checkOutput("overflow", overflow_o, m_ovf);
        checkOutput("ovf_cnt", ovf_cnt_o, expCnt());
    endtask

    // Called at a falling edge: check current outputs, drive this cycle's
    // inputs, advance the model across the next rising edge.
    task automatic applyStimulus(input bit v, input bit en, input bit rdy);
        bit hs, pop, acc, drop;
        int nidx;
        logic [31:0] meta;
        compareModel();
        rvfi_valid  = v;
        trace_en_i  = en;
        out_ready_i = rdy;
        hs   = (m_idx >= 0) && rdy;
        pop  = hs && (m_idx == 3);
        acc  = v && en && ((m_q.size() < DEPTH) || pop);
        drop = v && en && !acc;
        if (m_idx < 0)      nidx = (m_q.size() > 0) ? 0 : -1;
        else if (!hs)       nidx = m_idx;
        else if (m_idx < 3) nidx = m_idx + 1;
        else                nidx = ((m_q.size() - 1 + int'(acc)) > 0) ? 0 : -1;
        meta = '0;
        meta[31]    = m_ovf;
        meta[30]    = rvfi_trap;
        meta[29]    = rvfi_intr;
        meta[28]    = rvfi_halt;
        meta[27:26] = rvfi_mode;
        meta[25:21] = rvfi_rd_addr;
        meta[15:0]  = rvfi_order[15:0];
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_q.push_back({meta, rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata});
            m_ovf = 1'b0;
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end
        m_idx = nidx;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic applyReset();
        rvfi_valid = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("rst_valid", out_valid_o, 1'b0);
        checkOutput("rst_last", out_last_o, 1'b0);
        checkOutput("rst_data", out_data_o, 32'h0);
        checkOutput("rst_overflow", overflow_o, 1'b0);
        checkOutput("rst_ovf_cnt", ovf_cnt_o, 16'h0);
        m_q.delete();
        m_idx = -1;
        m_ovf = 1'b0;
        m_cnt = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic drainAll(input int budget);
        int n = 0;
        while ((m_q.size() > 0 || m_idx >= 0) && n < budget) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("drain_timeout", (m_q.size() > 0 || m_idx >= 0), 1'b0);
    endtask

    initial begin
        int n;
        @(negedge clk_i);
        applyReset();

        // Single retirement, latency and word order
        rvfi_pc_rdata = 32'h8000_0000; rvfi_insn = 32'h0000_0013; rvfi_rd_wdata = 32'h0;
        rvfi_rd_addr = 5'd0; rvfi_order = 64'd5; rvfi_trap = 0; rvfi_intr = 0;
        rvfi_halt = 0; rvfi_mode = 2'd0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("lat_cycle1_valid", out_valid_o, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("lat_w0_valid", out_valid_o, 1'b1);
        checkOutput("lat_w0_data", out_data_o, 32'h8000_0000);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("lat_w1_data", out_data_o, 32'h0000_0013);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("lat_w2_data", out_data_o, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("lat_w3_data", out_data_o, 32'h0000_0005);
        checkOutput("lat_w3_last", out_last_o, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("lat_idle_valid", out_valid_o, 1'b0);

        // Stall during W1 with ready 1,0,0,1 pattern around it
        randPayload();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("stall_w1_data", out_data_o, m_q[0][63:32]);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stall_w1_hold", out_data_o, m_q[0][63:32]);
        applyStimulus(1'b0, 1'b1, 1'b1);
        drainAll(20);

        // 17 back-to-back retirements with the output stalled
        for (int i = 0; i < 17; i++) begin
            randPayload();
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        checkOutput("ovf_flag", overflow_o, 1'b1);
`ifdef IBEXC_TRACE_OVF_CNT_EN
        checkOutput("ovf_cnt_one", ovf_cnt_o, 16'd1);
`else
        checkOutput("ovf_cnt_zero", ovf_cnt_o, 16'd0);
`endif
        // Drain one record, then capture one: it must carry the marker
        n = 0;
        while (m_q.size() == DEPTH && n < 10) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("drain_one_timeout", m_q.size(), DEPTH - 1);
        randPayload();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("ovf_cleared", overflow_o, 1'b0);
        checkOutput("marker_in_model", m_q[m_q.size()-1][127], 1'b1);
        drainAll(200);

        // Full buffer, capture coincides with the W3 handshake
        applyReset();
        for (int i = 0; i < DEPTH; i++) begin
            randPayload();
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        n = 0;
        while (m_idx != 3 && n < 10) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("reach_w3_timeout", m_idx, 3);
        randPayload();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("w3_cap_overflow", overflow_o, 1'b0);
        checkOutput("w3_cap_cnt", ovf_cnt_o, 16'd0);
        drainAll(200);

        // Reset while the serializer sits in W2 with 3 records buffered
        for (int i = 0; i < 3; i++) begin
            randPayload();
            applyStimulus(1'b1, 1'b1, 1'b0);
        end
        n = 0;
        while (m_idx != 2 && n < 10) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("reach_w2_timeout", m_idx, 2);
        applyReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("post_rst_quiet", out_valid_o, 1'b0);
        end

        // Randomized traffic including capture disabled and stalls
        for (int i = 0; i < 800; i++) begin
            randPayload();
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 85,
                          $urandom_range(0, 99) < 55);
        end
        drainAll(400);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
